// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - debounced switch level to press/release/click/long/double pulses
// Optional double-click detection is built when DOUBLE_CLICK_EN is defined.
module button_event_decoder #(
   parameter int c_LONG_LIMIT   = 12500000,
   parameter int c_DOUBLE_LIMIT = 6250000
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Switch,
   output logic o_Press,
   output logic o_Release,
   output logic o_Click,
   output logic o_Long,
   output logic o_Double,
   output logic o_Held
);

   localparam int MAX_LIMIT = (c_LONG_LIMIT > c_DOUBLE_LIMIT) ? c_LONG_LIMIT : c_DOUBLE_LIMIT;
   localparam int CNT_W     = $clog2(MAX_LIMIT + 1);

   localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(c_LONG_LIMIT - 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_PRESSED   = 3'd1;
   localparam logic [2:0] ST_LONG_HELD = 3'd2;
`ifdef DOUBLE_CLICK_EN
   localparam logic [2:0] ST_WAIT_SECOND    = 3'd3;
   localparam logic [2:0] ST_SECOND_PRESSED = 3'd4;
   localparam logic [CNT_W-1:0] DOUBLE_TERM = CNT_W'(c_DOUBLE_LIMIT - 1);
`endif

   logic [2:0]       state;
   logic [2:0]       next_state;
   logic [CNT_W-1:0] count;
   logic             prev_switch;
   logic             rise;
   logic             fall;
   logic             counting;
   logic             held_d;
   logic             press_d;
   logic             release_d;
   logic             click_d;
   logic             long_d;
   logic             double_d;

   assign rise = i_Switch & ~prev_switch;
   assign fall = ~i_Switch & prev_switch;

   // Edges are tested before counter terminals so an edge always wins a tie.
   always_comb begin
      next_state = state;
      press_d    = 1'b0;
      release_d  = 1'b0;
      click_d    = 1'b0;
      long_d     = 1'b0;
      double_d   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rise) begin
               press_d    = 1'b1;
               next_state = ST_PRESSED;
            end
         end
         ST_PRESSED: begin
            if (fall) begin
               release_d  = 1'b1;
`ifdef DOUBLE_CLICK_EN
               next_state = ST_WAIT_SECOND;
`else
               click_d    = 1'b1;
               next_state = ST_IDLE;
`endif
            end else if (count == LONG_TERM) begin
               long_d     = 1'b1;
               next_state = ST_LONG_HELD;
            end
         end
         ST_LONG_HELD: begin
            if (fall) begin
               release_d  = 1'b1;
               next_state = ST_IDLE;
            end
         end
`ifdef DOUBLE_CLICK_EN
         ST_WAIT_SECOND: begin
            if (rise) begin
               press_d    = 1'b1;
               next_state = ST_SECOND_PRESSED;
            end else if (count == DOUBLE_TERM) begin
               click_d    = 1'b1;
               next_state = ST_IDLE;
            end
         end
         ST_SECOND_PRESSED: begin
            if (fall) begin
               release_d  = 1'b1;
               double_d   = 1'b1;
               next_state = ST_IDLE;
            end else if (count == LONG_TERM) begin
               click_d    = 1'b1;
               long_d     = 1'b1;
               next_state = ST_LONG_HELD;
            end
         end
`endif
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      counting = (state == ST_PRESSED);
      held_d   = (next_state == ST_PRESSED) || (next_state == ST_LONG_HELD);
`ifdef DOUBLE_CLICK_EN
      counting = counting || (state == ST_WAIT_SECOND) || (state == ST_SECOND_PRESSED);
      held_d   = held_d || (next_state == ST_SECOND_PRESSED);
`endif
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state       <= ST_IDLE;
         count       <= '0;
         prev_switch <= 1'b0;
         o_Press     <= 1'b0;
         o_Release   <= 1'b0;
         o_Click     <= 1'b0;
         o_Long      <= 1'b0;
         o_Held      <= 1'b0;
      end else begin
         state       <= next_state;
         prev_switch <= i_Switch;
         if (next_state != state) begin
            count <= '0;
         end else if (counting && (count != '1)) begin
            count <= count + CNT_W'(1);
         end
         o_Press   <= press_d;
         o_Release <= release_d;
         o_Click   <= click_d;
         o_Long    <= long_d;
         o_Held    <= held_d;
      end
   end

`ifdef DOUBLE_CLICK_EN
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Double <= 1'b0;
      end else begin
         o_Double <= double_d;
      end
   end
`else
   assign o_Double = 1'b0;
`endif

endmodule
